// File: rtl/mul_pkg.sv
// Shared types and widths for the multiply issue stage.
package mul_pkg;

  localparam int XLEN   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

endpackage

// File: rtl/booth_multiplier_top.sv
// Combinational 32x32 radix-4 Booth multiplier; alu_signed selects signed*signed
// versus unsigned*unsigned and PRODUCT is the full 64-bit result.
module booth_multiplier_top
  import mul_pkg::*;
(
  input  logic [XLEN-1:0]   A,
  input  logic [XLEN-1:0]   B,
  input  logic              alu_signed,
  output logic [PROD_W-1:0] PRODUCT
);

  // Two extra bits let one recoder cover both signed and unsigned operands.
  localparam int EXT_W = XLEN + 2;
  localparam int NDIG  = EXT_W / 2;

  logic [EXT_W-1:0]  a_ext;
  logic [EXT_W-1:0]  b_ext;
  logic [EXT_W:0]    b_rec;
  logic [PROD_W-1:0] a_wide;
  logic [PROD_W-1:0] pp [NDIG];
  logic [PROD_W-1:0] sum_acc;

  assign a_ext  = {{2{alu_signed & A[XLEN-1]}}, A};
  assign b_ext  = {{2{alu_signed & B[XLEN-1]}}, B};
  assign b_rec  = {b_ext, 1'b0};
  assign a_wide = {{(PROD_W-EXT_W){a_ext[EXT_W-1]}}, a_ext};

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_pp
      logic [2:0]        digit;
      logic [PROD_W-1:0] mag;

      assign digit = b_rec[2*gi+2 -: 3];

      always_comb begin
        mag = '0;
        case (digit)
          3'b001, 3'b010: mag = a_wide;
          3'b011:         mag = a_wide << 1;
          3'b100:         mag = -(a_wide << 1);
          3'b101, 3'b110: mag = -a_wide;
          default:        mag = '0;
        endcase
      end

      assign pp[gi] = mag << (2*gi);
    end
  endgenerate

  always_comb begin
    sum_acc = '0;
    for (int i = 0; i < NDIG; i++) begin
      sum_acc = sum_acc + pp[i];
    end
  end

  assign PRODUCT = sum_acc;

endmodule

// File: rtl/mul_issue_stage.sv
// Two-stage valid/ready multiply pipeline (MUL/MULH/MULHSU/MULHU) with tags.
// Optional MUL_FLUSH_EN adds a flush input that drops all in-flight work.
module mul_issue_stage
  import mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  logic flush_w;
`ifdef MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic             s1_valid_reg, s1_valid_next;
  logic [XLEN-1:0]  s1_a_reg, s1_a_next;
  logic [XLEN-1:0]  s1_b_reg, s1_b_next;
  mul_op_e          s1_op_reg, s1_op_next;
  logic [TAG_W-1:0] s1_tag_reg, s1_tag_next;

  logic             out_valid_reg, out_valid_next;
  logic [XLEN-1:0]  out_data_reg, out_data_next;
  logic [TAG_W-1:0] out_tag_reg, out_tag_next;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             alu_signed;
  logic [PROD_W-1:0] product;
  logic [XLEN-1:0]  result;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = (!s1_valid_reg || s2_adv) && !flush_w;
  assign in_fire  = in_valid && in_ready;

  assign alu_signed = (s1_op_reg == MULH) || (s1_op_reg == MULHSU);

  booth_multiplier_top u_mult (
    .A          (s1_a_reg),
    .B          (s1_b_reg),
    .alu_signed (alu_signed),
    .PRODUCT    (product)
  );

  // MULHSU reuses the signed product: adding a when b is negative turns
  // the signed b back into its unsigned value for the high word.
  always_comb begin
    result = product[PROD_W-1:XLEN];
    case (s1_op_reg)
      MUL_LO:  result = product[XLEN-1:0];
      MULHSU:  result = product[PROD_W-1:XLEN] + (s1_b_reg[XLEN-1] ? s1_a_reg : '0);
      default: result = product[PROD_W-1:XLEN];
    endcase
  end

  always_comb begin
    s1_valid_next  = s1_valid_reg;
    s1_a_next      = s1_a_reg;
    s1_b_next      = s1_b_reg;
    s1_op_next     = s1_op_reg;
    s1_tag_next    = s1_tag_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_tag_next   = out_tag_reg;

    if (in_fire) begin
      s1_valid_next = 1'b1;
      s1_a_next     = in_a;
      s1_b_next     = in_b;
      s1_op_next    = mul_op_e'(in_op);
      s1_tag_next   = in_tag;
    end else if (s1_adv) begin
      s1_valid_next = 1'b0;
    end

    if (s1_adv) begin
      out_valid_next = 1'b1;
      out_data_next  = result;
      out_tag_next   = s1_tag_reg;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end

    if (flush_w) begin
      s1_valid_next  = 1'b0;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_op_reg     <= MUL_LO;
      s1_tag_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
    end else begin
      s1_valid_reg  <= s1_valid_next;
      s1_a_reg      <= s1_a_next;
      s1_b_reg      <= s1_b_next;
      s1_op_reg     <= s1_op_next;
      s1_tag_reg    <= s1_tag_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_tag_reg   <= out_tag_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Self-checking bench for mul_issue_stage: directed vectors, backpressure,
// reset and flush sequences, then random traffic against a scoreboard.
module tb_mul_issue_stage;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef MUL_FLUSH_EN
  logic             flush;
`endif

  mul_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef MUL_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  logic [31:0]      exp_data_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  logic [31:0] bp_a[1:4];
  logic [31:0] bp_b[1:4];
  logic [1:0]  bp_op[1:4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: operands widened per the op's signedness, multiplied exactly.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic signed [127:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'b0, a};
    sb = (op == 2'b01) ? {{96{b[31]}}, b} : {96'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // One request with an idle pipeline: checks acceptance, latency, data, tag.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp, input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a; in_b = b; in_op = op; in_tag = tag;
    #1;
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_early_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, out_tag, tag);
    $display("txn %s op=%0d a=%h b=%h data=%h tag=%0d", name, op, a, b, out_data, out_tag);
    @(posedge clk); #1;
  endtask

  logic             acc, take;
  logic             hold_prev;
  logic [31:0]      hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic [31:0]      ed;
  logic [TAG_W-1:0] et;
  int               k, got;

  initial begin
    vecs[0]  = '{32'd15,        32'd10,        2'b00, 32'd150};
    vecs[1]  = '{32'h80000000,  32'hFFFFFFFF,  2'b01, 32'h00000000};
    vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,  2'b00, 32'h80000000};
    vecs[3]  = '{32'hFFFFFFFF,  32'd2,         2'b11, 32'h00000001};
    vecs[4]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b10, 32'hFFFFFFFF};
    vecs[5]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b01, 32'h00000000};
    vecs[6]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b11, 32'hFFFFFFFE};
    vecs[7]  = '{32'd2,         32'hFFFFFFFF,  2'b10, 32'h00000001};
    vecs[8]  = '{32'h80000000,  32'h80000000,  2'b01, 32'h40000000};
    vecs[9]  = '{32'h80000000,  32'h80000000,  2'b10, 32'hC0000000};
    vecs[10] = '{32'h80000000,  32'h80000000,  2'b11, 32'h40000000};
    vecs[11] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  2'b00, 32'h00000001};
    vecs[12] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  2'b01, 32'h3FFFFFFF};
    vecs[13] = '{32'hFFFFFFFE,  32'd3,         2'b01, 32'hFFFFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0;
`ifdef MUL_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_single(vecs[i].a, vecs[i].b, vecs[i].op, TAG_W'(i), vecs[i].exp,
                 $sformatf("vec%0d", i));
    end

    // Backpressure: four requests, consumer stalled for five cycles.
    for (int t = 1; t <= 4; t++) begin
      bp_a[t] = 32'(t * 1000 + 7); bp_b[t] = 32'hFFFFFFF0 + 32'(t); bp_op[t] = 2'(t - 1);
    end
    out_ready = 1'b0; k = 1; got = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k <= 4);
      if (k <= 4) begin
        in_a = bp_a[k]; in_b = bp_b[k]; in_op = bp_op[k]; in_tag = TAG_W'(k);
      end
      #1;
      acc = in_valid && in_ready;
      if (c >= 2) check($sformatf("bp_stall_in_ready_c%0d", c), in_ready, 0);
      check($sformatf("bp_stall_no_output_c%0d", c), out_valid && out_ready, 0);
      @(posedge clk); #1;
      if (acc) k++;
    end
    check("bp_accepted", k - 1, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (k <= 4);
      if (k <= 4) begin
        in_a = bp_a[k]; in_b = bp_b[k]; in_op = bp_op[k]; in_tag = TAG_W'(k);
      end
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        got++;
        check($sformatf("bp_order%0d", got), out_tag, got);
        check($sformatf("bp_data%0d", got), out_data, ref_mul(bp_a[got], bp_b[got], bp_op[got]));
        $display("txn bp tag=%0d data=%h", out_tag, out_data);
      end
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("bp_count", got, 4);

    // Reset with both stages full.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 32'd77 + 32'(c); in_b = 32'd3; in_op = 2'b00; in_tag = TAG_W'(c + 10);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("midrst_full", out_valid && !in_ready, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    run_single(32'd1000, 32'd2000, 2'b00, 4'd5, 32'd2000000, "post_rst");

`ifdef MUL_FLUSH_EN
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 32'd5 + 32'(c); in_b = 32'd9; in_op = 2'b00; in_tag = TAG_W'(c + 6);
      @(posedge clk); #1;
    end
    in_a = 32'd123; in_b = 32'd4; in_op = 2'b00; in_tag = 4'd9; in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("flush_no_out%0d", c), out_valid, 0);
      @(posedge clk); #1;
    end
    run_single(32'd123, 32'd4, 2'b00, 4'd9, 32'd492, "post_flush");
`endif

    // Random traffic against the scoreboard.
    hold_prev = 1'b0; hold_data = '0; hold_tag = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pick();
      in_b      = pick();
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_in_ready", in_ready, (exp_data_q.size() < 2) || out_ready);
      if (hold_prev) begin
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_data", out_data, hold_data);
        check("rnd_hold_tag", out_tag, hold_tag);
      end
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_tag  = out_tag;
      if (take) begin
        if (exp_data_q.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          ed = exp_data_q.pop_front();
          et = exp_tag_q.pop_front();
          check("rnd_data", out_data, ed);
          check("rnd_tag", out_tag, et);
          $display("txn rnd tag=%0d data=%h", out_tag, out_data);
        end
      end
      if (acc) begin
        exp_data_q.push_back(ref_mul(in_a, in_b, in_op));
        exp_tag_q.push_back(in_tag);
      end
      check("rnd_in_flight", exp_data_q.size() <= 2, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_data_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        ed = exp_data_q.pop_front();
        et = exp_tag_q.pop_front();
        check("drain_data", out_data, ed);
        check("drain_tag", out_tag, et);
        $display("txn drain tag=%0d data=%h", out_tag, out_data);
      end
      @(posedge clk); #1;
    end
    check("drain_empty", exp_data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_issue_stage.md
# mul_issue_stage

Two-stage valid/ready wrapper around the combinational `booth_multiplier_top`: registers operands, drives the 32×32 multiplier, captures the 64-bit `PRODUCT` and returns one 32-bit result word per operation. Sits between the ALU issue logic and writeback. Adds backpressure, in-order tagging and the four RV32M multiply flavours (MUL, MULH, MULHSU, MULHU).

## Interface
- `TAG_W`, default 4: width of the opaque request tag.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: request present.
- `in_ready` output 1: stage accepts the request this cycle.
- `in_a` input 32: multiplicand (rs1).
- `in_b` input 32: multiplier (rs2).
- `in_op` input 2: operation select. 00 = MUL (low word). 01 = MULH (signed×signed, high). 10 = MULHSU (signed a × unsigned b, high). 11 = MULHU (unsigned, high).
- `in_tag` input `TAG_W`: returned unchanged with the result.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes the result.
- `out_data` output 32: result word.
- `out_tag` output `TAG_W`: tag of the result.
- `flush` input 1: present only with `MUL_FLUSH_EN`; see Configuration.

## Operation
- **S1 (operand register).** Holds `a`, `b`, `op`, `tag` and `s1_valid`. Feeds `booth_multiplier_top`:
  - `A = a`, `B = b`.
  - `alu_signed = 1` for op 01 and op 10; `alu_signed = 0` for op 00 and op 11.
- **S2 (result register).** Holds `out_data`, `out_tag` and `out_valid`.
- **Result select:**
  - op 00: `PRODUCT[31:0]`. The low word is identical in both signedness modes.
  - op 01 and op 11: `PRODUCT[63:32]`.
  - op 10: `PRODUCT[63:32] + (b[31] ? a : 0)`, mod 2^32. This corrects the signed×signed high word to signed×unsigned.
- **Handshakes:**
  - Transfer occurs when valid and ready are both high in the same cycle.
  - `s2_adv = !out_valid || out_ready`.
  - `s1_adv = s1_valid && s2_adv`.
  - `in_ready = !s1_valid || s2_adv` (combinational).
- **Ordering and capacity.** Results emerge in acceptance order. At most 2 operations are in flight. No request is dropped or duplicated.
- **Simultaneous events.**
  - S1 may load a new request in the same cycle it advances into S2.
  - S2 may load in the same cycle its current result is consumed.
- **Output stability.** While `out_valid && !out_ready`, `out_data` and `out_tag` hold stable.

## Timing
- **Latency.** A request accepted at edge N appears with `out_valid = 1` after edge N+1, provided S2 is free. The combinational multiplier path spans S1→S2.
- **Throughput.** One operation per cycle with `out_ready` held high.
- **Reset** (`rst_n` low at an edge):
  - `s1_valid = 0`, `out_valid = 0`, `out_data = 0`, `out_tag = 0`.
  - Therefore `in_ready = 1` in the first cycle after reset.
  - Reset during an operation discards all in-flight work. No result appears for it.
- **Backpressure.** With `out_ready` low and both stages full, `in_ready` = 0 on the following cycle.

## Configuration
- **`MUL_FLUSH_EN` defined:**
  - Adds the `flush` input.
  - `flush = 1` at an edge clears `s1_valid` and `out_valid`; data registers keep their values.
  - A request offered in that same cycle is not accepted: `in_ready` is forced to 0 while `flush = 1`.
  - Flush takes priority over any advance.
- **`MUL_FLUSH_EN` undefined:** no `flush` port; pipeline behaviour is otherwise identical.

## Structure
- **Package `mul_pkg`:**
  - `mul_op_e` enum (`MUL_LO = 2'b00`, `MULH = 2'b01`, `MULHSU = 2'b10`, `MULHU = 2'b11`).
  - `XLEN = 32` and `PROD_W = 64` constants.
- **Sub-module:** the existing `booth_multiplier_top`, instantiated once. The result select and MULHSU fixup live inline; no further sub-modules.

## Test plan
- **MUL low word:** op 00, a=15, b=10, accepted at edge N, `out_ready`=1 → `out_data`=150 valid after edge N+1. Tag echoed.
- **Signed edge case:** op 01, a=0x80000000, b=0xFFFFFFFF → `out_data`=0x00000000. Same operands with op 00 → `out_data`=0x80000000.
- **Unsigned / signed×unsigned:**
  - op 11, a=0xFFFFFFFF, b=2 → `out_data`=0x00000001.
  - op 10, a=0xFFFFFFFF, b=0xFFFFFFFF → `out_data`=0xFFFFFFFF.
- **Backpressure:** 4 back-to-back requests (tags 1..4) with `out_ready`=0 for 5 cycles. Required:
  - Only tags 1 and 2 accepted; `in_ready`=0 until release.
  - After release, results emerge in order 1,2,3,4 with correct data and none lost.
- **Reset mid-operation:** `rst_n`=0 for one edge with both stages full → `out_valid`=0, `out_data`=0, `in_ready`=1 next cycle. A following op 00, a=1000, b=2000 returns 2000000.
- **Flush (`MUL_FLUSH_EN`):** `flush` pulsed with 2 ops in flight and `in_valid`=1. Required:
  - Nothing is returned for the 2 flushed ops.
  - The request offered during the flush cycle is not accepted.
  - A re-offered request completes normally.
